adder_result_checker: RTL

- Synthesizable response checker for the 8-bit carry-select adder; it is the receiving end of the operand stimulus stream.
- It captures each applied operand set {inp1, inp2, carryIn} and aligns it to the adder's configurable latency.
- It compares the adder's {carryOut, sum} against an internally computed golden result and keeps pass/fail counts and a first-failure record.
- It sits beside the adder in CA1 benches and on-board self-test wrappers.

---
 rtl/adder_result_checker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/adder_result_checker.sv
// Response checker for the carry-select adder: recomputes the golden {cout,sum},
// aligns it to the adder latency and keeps pass/fail counts plus a first-failure record.
module adder_result_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             carryIn,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH:0]   first_fail_exp,
  output logic [WIDTH:0]   first_fail_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] chk_next;

  logic             accept;
  logic             start_take;
  logic [WIDTH:0]   golden;
  logic [WIDTH:0]   got;
  logic             tap_vld;
  logic [WIDTH:0]   tap_exp;
  logic [CNT_W-1:0] tap_idx;

  always_comb begin
    start_take = start && (state != S_RUN);
    accept     = (state == S_RUN) && vec_valid && (acc_cnt < num_lat);
    golden     = {1'b0, inp1} + {1'b0, inp2} + {{WIDTH{1'b0}}, carryIn};
    got        = {dut_cout, dut_sum};
    chk_next   = chk_cnt + 1'b1;
  end

  generate
    if (LAT == 0) begin : g_comb
      always_comb begin
        tap_vld = accept;
        tap_exp = golden;
        tap_idx = acc_cnt;
      end
    end else begin : g_dly
      logic             vld_q [LAT];
      logic [WIDTH:0]   exp_q [LAT];
      logic [CNT_W-1:0] idx_q [LAT];

      // A new start flushes in-flight entries so they cannot be scored in the next run.
      always_ff @(posedge clk) begin
        if (rst || start_take) begin
          for (int unsigned i = 0; i < LAT; i++) begin
            vld_q[i] <= 1'b0;
            exp_q[i] <= '0;
            idx_q[i] <= '0;
          end
        end else begin
          vld_q[0] <= accept;
          exp_q[0] <= golden;
          idx_q[0] <= acc_cnt;
          for (int unsigned i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            exp_q[i] <= exp_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      always_comb begin
        tap_vld = vld_q[LAT-1] && (state == S_RUN);
        tap_exp = exp_q[LAT-1];
        tap_idx = idx_q[LAT-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      num_lat          <= '0;
      acc_cnt          <= '0;
      chk_cnt          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mismatch         <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_exp   <= '0;
      first_fail_got   <= '0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_take) begin
            num_lat          <= num_vec;
            acc_cnt          <= '0;
            chk_cnt          <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_exp   <= '0;
            first_fail_got   <= '0;
            if (num_vec == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
          end
          if (tap_vld) begin
            chk_cnt <= chk_next;
            if (tap_exp == got) begin
              if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            end else begin
              if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
              mismatch <= 1'b1;
              if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_idx   <= tap_idx;
                first_fail_exp   <= tap_exp;
                first_fail_got   <= got;
              end
            end
            if (chk_next == num_lat) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
